// File: rtl/sgmii_link_sequencer.sv
// EMAC1 SGMII PCS/LVDS SERDES bring-up sequencer: gates SERDES/PCS resets on PLL lock,
// waits for auto-negotiation, supervises the link with retry/backoff and exports status.
module sgmii_link_sequencer #(
    parameter int PLL_STABLE_CYC = 1024,
    parameter int SERDES_RST_CYC = 256,
    parameter int PCS_RST_CYC    = 64,
    parameter int AN_TIMEOUT_CYC = 1000000,
    parameter int LINK_DEB_CYC   = 128,
    parameter int BACKOFF_CYC    = 4096,
    parameter int MAX_RETRIES    = 8
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        enable,
    input  logic        restart,
    input  logic        pll_locked,
    input  logic        pcs_link,
    input  logic        pcs_an_done,
    input  logic        set_1000,
    input  logic        set_100,
    input  logic        set_10,
    output logic        serdes_reset,
    output logic        pcs_reset,
    output logic        link_up,
    output logic [1:0]  speed,
    output logic        fail,
    output logic        irq,
    output logic [12:0] debug_status
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_PLL   = 3'd1;
    localparam logic [2:0] S_SERDES_RST = 3'd2;
    localparam logic [2:0] S_PCS_RST    = 3'd3;
    localparam logic [2:0] S_AN_WAIT    = 3'd4;
    localparam logic [2:0] S_LINK_UP    = 3'd5;
    localparam logic [2:0] S_BACKOFF    = 3'd6;
    localparam logic [2:0] S_FAIL       = 3'd7;

    localparam int M1      = (PLL_STABLE_CYC > SERDES_RST_CYC) ? PLL_STABLE_CYC : SERDES_RST_CYC;
    localparam int M2      = (M1 > PCS_RST_CYC) ? M1 : PCS_RST_CYC;
    localparam int M3      = (M2 > AN_TIMEOUT_CYC) ? M2 : AN_TIMEOUT_CYC;
    localparam int CNT_MAX = (M3 > BACKOFF_CYC) ? M3 : BACKOFF_CYC;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam int DW      = $clog2(LINK_DEB_CYC) + 1;

    logic [2:0]    state;
    logic [2:0]    state_n;
    logic [CW-1:0] cnt;
    logic [DW-1:0] deb;
    logic [3:0]    retries;
    logic          link_up_d;
    logic          pll_q;
    logic          an_q;
    logic          an_ok;
    logic          deb_hit;
    logic          pll_lost;
    logic          restart_hit;
    logic          moving;
    logic [1:0]    spd;

    assign an_ok       = pcs_link && pcs_an_done;
    assign restart_hit = enable && restart;
    assign pll_lost    = !pll_locked && (state >= S_SERDES_RST) && (state <= S_BACKOFF);

    always_comb begin
        spd = 2'b11;
        if (set_1000)     spd = 2'b10;
        else if (set_100) spd = 2'b01;
        else if (set_10)  spd = 2'b00;
    end

    // deb tracks "link good" while negotiating and "link lost" while up.
    always_comb begin
        deb_hit = 1'b0;
        if (state == S_AN_WAIT)      deb_hit = an_ok;
        else if (state == S_LINK_UP) deb_hit = !pcs_link;
    end

    always_comb begin
        state_n = state;
        if (!enable) begin
            state_n = S_IDLE;
        end else if (pll_lost || restart) begin
            state_n = S_WAIT_PLL;
        end else begin
            case (state)
                S_IDLE:       state_n = S_WAIT_PLL;
                S_WAIT_PLL:   if (pll_locked && cnt == CW'(PLL_STABLE_CYC)) state_n = S_SERDES_RST;
                S_SERDES_RST: if (cnt == CW'(SERDES_RST_CYC - 1)) state_n = S_PCS_RST;
                S_PCS_RST:    if (cnt == CW'(PCS_RST_CYC - 1)) state_n = S_AN_WAIT;
                S_AN_WAIT: begin
                    if (deb_hit && deb == DW'(LINK_DEB_CYC - 1))  state_n = S_LINK_UP;
                    else if (cnt == CW'(AN_TIMEOUT_CYC - 1))     state_n = S_BACKOFF;
                end
                S_LINK_UP:    if (deb_hit && deb == DW'(LINK_DEB_CYC - 1)) state_n = S_BACKOFF;
                S_BACKOFF: begin
                    if (retries >= 4'(MAX_RETRIES))          state_n = S_FAIL;
                    else if (cnt == CW'(BACKOFF_CYC - 1))    state_n = S_PCS_RST;
                end
                default:      state_n = state;
            endcase
        end
    end

    // A restart re-enters WAIT_PLL even from WAIT_PLL, so it counts as a transition.
    assign moving = (state_n != state) || restart_hit;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            deb          <= '0;
            retries      <= 4'd0;
            fail         <= 1'b0;
            serdes_reset <= 1'b1;
            pcs_reset    <= 1'b1;
            link_up      <= 1'b0;
            link_up_d    <= 1'b0;
            speed        <= 2'b11;
            irq          <= 1'b0;
            pll_q        <= 1'b0;
            an_q         <= 1'b0;
        end else begin
            state <= state_n;
            if (moving) begin
                cnt <= '0;
                deb <= '0;
            end else begin
                if (state == S_WAIT_PLL && !pll_locked) cnt <= '0;
                else if (cnt != '1)                     cnt <= cnt + CW'(1);
                if (!deb_hit)       deb <= '0;
                else if (deb != '1) deb <= deb + DW'(1);
            end

            if (restart_hit) begin
                retries <= 4'd0;
                fail    <= 1'b0;
            end else if (moving) begin
                if (state_n == S_BACKOFF && retries != 4'hf) retries <= retries + 4'd1;
                else if (state_n == S_LINK_UP)               retries <= 4'd0;
                if (state_n == S_FAIL) fail <= 1'b1;
            end

            serdes_reset <= (state_n == S_IDLE) || (state_n == S_WAIT_PLL) ||
                            (state_n == S_SERDES_RST) || (state_n == S_FAIL);
            pcs_reset    <= !((state_n == S_AN_WAIT) || (state_n == S_LINK_UP));
            link_up      <= (state_n == S_LINK_UP);
            speed        <= (state_n == S_LINK_UP) ? spd : 2'b11;
            link_up_d    <= link_up;
            irq          <= link_up ^ link_up_d;
            pll_q        <= pll_locked;
            an_q         <= pcs_an_done;
        end
    end

    assign debug_status = {pll_q, an_q, fail, link_up, speed, retries, state};

endmodule

// File: tb/tb_sgmii_link_sequencer.sv
// Bench for sgmii_link_sequencer: directed bring-up/fault scenarios then random stimulus,
// every cycle compared against a timestamp-based reference model through an expected queue.
module tb_sgmii_link_sequencer;

    localparam int P_PLL  = 8;
    localparam int P_SRST = 4;
    localparam int P_PCS  = 4;
    localparam int P_AN   = 1000;
    localparam int P_DEB  = 4;
    localparam int P_BO   = 16;
    localparam int P_MAX  = 3;

    localparam int S_IDLE = 0, S_WAIT_PLL = 1, S_SERDES_RST = 2, S_PCS_RST = 3;
    localparam int S_AN_WAIT = 4, S_LINK_UP = 5, S_BACKOFF = 6, S_FAIL = 7;

    logic        clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic        enable = 1'b0;
    logic        restart = 1'b0;
    logic        pll_locked = 1'b0;
    logic        pcs_link = 1'b0;
    logic        pcs_an_done = 1'b0;
    logic        set_1000 = 1'b0;
    logic        set_100 = 1'b0;
    logic        set_10 = 1'b0;
    logic        serdes_reset;
    logic        pcs_reset;
    logic        link_up;
    logic [1:0]  speed;
    logic        fail;
    logic        irq;
    logic [12:0] debug_status;

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    sgmii_link_sequencer #(
        .PLL_STABLE_CYC(P_PLL), .SERDES_RST_CYC(P_SRST), .PCS_RST_CYC(P_PCS),
        .AN_TIMEOUT_CYC(P_AN), .LINK_DEB_CYC(P_DEB), .BACKOFF_CYC(P_BO), .MAX_RETRIES(P_MAX)
    ) dut (
        .clk_clk(clk), .reset_reset(reset_reset), .enable(enable), .restart(restart),
        .pll_locked(pll_locked), .pcs_link(pcs_link), .pcs_an_done(pcs_an_done),
        .set_1000(set_1000), .set_100(set_100), .set_10(set_10),
        .serdes_reset(serdes_reset), .pcs_reset(pcs_reset), .link_up(link_up), .speed(speed),
        .fail(fail), .irq(irq), .debug_status(debug_status)
    );

    // Reference model: state residency measured as (cycle - entry cycle), debounce as run lengths.
    int       cyc = 0, t_entry = 0, lock_cnt = 0, run = 0, chg_cyc = -100;
    int       m_state = S_IDLE, m_retries = 0;
    bit       m_fail = 0, m_link = 0, m_pll = 0, m_an = 0, m_irq = 0;
    bit [1:0] m_speed = 2'b11;

    function automatic bit [1:0] speed_of(input bit s1000, input bit s100, input bit s10);
        if (s1000) return 2'b10;
        if (s100)  return 2'b01;
        if (s10)   return 2'b00;
        return 2'b11;
    endfunction

    always @(posedge clk) begin
        int  nxt;
        bit  reenter;
        bit  new_link;
        bit  m_ser, m_pcs;
        cyc++;
        if (reset_reset) begin
            m_state = S_IDLE; t_entry = cyc; lock_cnt = 0; run = 0; chg_cyc = -100;
            m_retries = 0; m_fail = 0; m_link = 0; m_pll = 0; m_an = 0; m_irq = 0;
            m_speed = 2'b11;
        end else begin
            nxt = m_state;
            reenter = 0;
            if (!enable) begin
                nxt = S_IDLE;
            end else if ((!pll_locked && m_state >= S_SERDES_RST && m_state <= S_BACKOFF) || restart) begin
                nxt = S_WAIT_PLL;
                reenter = 1;
            end else begin
                case (m_state)
                    S_IDLE: nxt = S_WAIT_PLL;
                    S_WAIT_PLL: begin
                        if (!pll_locked)            lock_cnt = 0;
                        else if (lock_cnt == P_PLL) nxt = S_SERDES_RST;
                        else                        lock_cnt++;
                    end
                    S_SERDES_RST: if (cyc - t_entry == P_SRST) nxt = S_PCS_RST;
                    S_PCS_RST:    if (cyc - t_entry == P_PCS) nxt = S_AN_WAIT;
                    S_AN_WAIT: begin
                        run = (pcs_link && pcs_an_done) ? run + 1 : 0;
                        if (run == P_DEB)                 nxt = S_LINK_UP;
                        else if (cyc - t_entry == P_AN)   nxt = S_BACKOFF;
                    end
                    S_LINK_UP: begin
                        run = !pcs_link ? run + 1 : 0;
                        if (run == P_DEB) nxt = S_BACKOFF;
                    end
                    S_BACKOFF: begin
                        if (m_retries >= P_MAX)         nxt = S_FAIL;
                        else if (cyc - t_entry == P_BO) nxt = S_PCS_RST;
                    end
                    default: nxt = m_state;
                endcase
            end
            if (enable && restart) begin
                m_retries = 0;
                m_fail = 0;
            end
            if (nxt != m_state || reenter) begin
                t_entry = cyc; lock_cnt = 0; run = 0;
                if (nxt == S_BACKOFF) m_retries = (m_retries < 15) ? m_retries + 1 : 15;
                if (nxt == S_LINK_UP) m_retries = 0;
                if (nxt == S_FAIL)    m_fail = 1;
            end
            m_state  = nxt;
            new_link = (nxt == S_LINK_UP);
            m_irq    = (cyc == chg_cyc + 1);
            if (new_link != m_link) chg_cyc = cyc;
            m_link   = new_link;
            m_speed  = new_link ? speed_of(set_1000, set_100, set_10) : 2'b11;
            m_pll    = pll_locked;
            m_an     = pcs_an_done;
        end
        m_ser = (m_state == S_IDLE || m_state == S_WAIT_PLL || m_state == S_SERDES_RST || m_state == S_FAIL);
        m_pcs = !(m_state == S_AN_WAIT || m_state == S_LINK_UP);
        exp_q.push_back({m_ser, m_pcs, m_link, m_speed, m_fail, m_irq,
                         m_pll, m_an, m_fail, m_link, m_speed, 4'(m_retries), 3'(m_state)});
    end

    always @(negedge clk) begin
        logic [19:0] e;
        logic [19:0] got;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {serdes_reset, pcs_reset, link_up, speed, fail, irq, debug_status};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got=%05h exp=%05h", $time, got, e);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic wait_state(input int s, input int bound, output int n);
        n = 0;
        while (debug_status[2:0] !== 3'(s) && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (debug_status[2:0] !== 3'(s)) begin
            errors++;
            $display("FAIL wait_state%0d got=%0d exp=%0d", s, debug_status[2:0], s);
        end
    endtask

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_vec", {serdes_reset, pcs_reset, link_up, speed, fail, irq, debug_status},
              {1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 13'b0_0_0_0_11_0000_000});
        reset_reset = 0;
        pll_locked = 1;
        repeat (2) @(negedge clk);

        // Clean bring-up
        enable = 1;
        wait_state(S_PCS_RST, 100, n);
        check("serdes_latency", n, P_PLL + P_SRST + 2);
        check("serdes_low", serdes_reset, 0);
        wait_state(S_AN_WAIT, 100, n);
        check("pcs_latency", n, P_PCS);
        pcs_link = 1; pcs_an_done = 1; set_1000 = 1;
        wait_state(S_LINK_UP, 100, n);
        check("link_latency", n, P_DEB);
        check("speed_1000", speed, 2'b10);
        @(negedge clk);
        check("irq_rise", irq, 1);
        @(negedge clk);
        check("irq_clear", irq, 0);

        // Speed resolution
        set_1000 = 0; set_100 = 1;
        @(negedge clk);
        check("speed_100", speed, 2'b01);
        set_1000 = 1; set_10 = 1;
        @(negedge clk);
        check("speed_prio", speed, 2'b10);
        set_1000 = 0; set_100 = 0; set_10 = 0;
        @(negedge clk);
        check("speed_none", speed, 2'b11);

        // Link debounce
        pcs_link = 0;
        repeat (P_DEB - 1) @(negedge clk);
        pcs_link = 1;
        repeat (3) @(negedge clk);
        check("short_drop", {link_up, debug_status[2:0]}, {1'b1, 3'(S_LINK_UP)});
        pcs_link = 0;
        wait_state(S_BACKOFF, 20, n);
        check("drop_latency", n, P_DEB);
        check("drop_status", {link_up, debug_status[6:3]}, {1'b0, 4'd1});
        @(negedge clk);
        check("irq_fall", irq, 1);
        pcs_link = 1;
        wait_state(S_LINK_UP, 200, n);
        check("retries_clear", debug_status[6:3], 0);

        // PLL glitch during AN_WAIT
        pcs_link = 0; pcs_an_done = 0;
        wait_state(S_AN_WAIT, 200, n);
        pll_locked = 0;
        @(negedge clk);
        pll_locked = 1;
        check("glitch_state", {serdes_reset, pcs_reset, debug_status[6:3], debug_status[2:0]},
              {1'b1, 1'b1, 4'd1, 3'(S_WAIT_PLL)});
        wait_state(S_PCS_RST, 100, n);
        check("reseq_latency", n, P_PLL + P_SRST + 1);

        // AN timeout after restart
        restart = 1;
        @(negedge clk);
        restart = 0;
        check("restart_clr", {debug_status[6:3], debug_status[2:0]}, {4'd0, 3'(S_WAIT_PLL)});
        wait_state(S_AN_WAIT, 100, n);
        wait_state(S_BACKOFF, P_AN + 100, n);
        check("an_timeout", n, P_AN);
        check("retry_1", debug_status[6:3], 1);
        wait_state(S_FAIL, 3 * P_AN, n);
        check("fail_status", {fail, serdes_reset, pcs_reset, debug_status[10], debug_status[6:3]},
              {1'b1, 1'b1, 1'b1, 1'b1, 4'(P_MAX)});

        // Override priority
        restart = 1; pll_locked = 0;
        @(negedge clk);
        restart = 0; pll_locked = 1;
        check("restart_pll", {fail, debug_status[6:3], debug_status[2:0]}, {1'b0, 4'd0, 3'(S_WAIT_PLL)});
        wait_state(S_AN_WAIT, 100, n);
        enable = 0;
        @(negedge clk);
        check("enable_off", debug_status[2:0], S_IDLE);
        enable = 1;

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset_reset = ($urandom_range(0, 599) == 0);
            enable      = ($urandom_range(0, 149) != 0);
            restart     = ($urandom_range(0, 249) == 0);
            pll_locked  = ($urandom_range(0, 119) != 0);
            if ($urandom_range(0, 9) == 0) pcs_link    = ~pcs_link;
            if ($urandom_range(0, 11) == 0) pcs_an_done = ~pcs_an_done;
            if ($urandom_range(0, 7) == 0) set_1000    = ~set_1000;
            if ($urandom_range(0, 7) == 0) set_100     = ~set_100;
            if ($urandom_range(0, 7) == 0) set_10      = ~set_10;
        end
        reset_reset = 0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
